// File: rtl/cmd_loader.sv
`default_nettype none
// ============================================================================
// Module   : cmd_loader
// Purpose  : Program store and run controller for the cpu. Receives a
//            length-prefixed byte stream (16-bit little-endian word count,
//            then 4 bytes per word, little-endian) and packs it into 32-bit
//            command words. Once a load completes it holds cmd_en high and
//            serves registered command fetches. When the cpu reports res_en,
//            it captures res, drops cmd_en and waits for a reload.
// Ports    : sys_clk, sys_rst_n      - clock, asynchronous active-low reset
//            rx_data, rx_valid       - incoming program bytes (1-cycle strobe)
//            cmd_id -> cmd           - fetch index -> registered command word
//            cmd_en                  - cpu run enable
//            res, res_en             - cpu result and result-valid/halt
//            result, result_valid    - captured cpu result
//            busy                    - a load is in progress
//            ovf                     - last load declared more words than DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module cmd_loader #(
  parameter int ADDR_W = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [15:0] cmd_id,
  output logic [31:0] cmd,
  output logic        cmd_en,
  input  logic [31:0] res,
  input  logic        res_en,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [1:0]  r_lane;
  logic [23:0] r_word;      // lanes 0..2; lane 3 comes straight from rx_data
  logic [31:0] r_cmd;
  logic [31:0] r_result;
  logic        r_result_valid;
  logic        r_ovf;

  logic [31:0] r_mem [DEPTH];

  logic [15:0] w_len_full;
  logic        w_load_done;
  logic        w_load_byte;
  logic        w_word_last;
  logic        w_mem_we;
  logic        w_fetch_ok;

  // Length as it will be once the high byte in rx_data is latched.
  assign w_len_full  = {rx_data, r_len[7:0]};
  // Index has already reached N: the final word was written on a prior edge,
  // so the next edge moves to RUN (cmd_en one edge after the final byte).
  assign w_load_done = (r_idx == r_len);
  assign w_load_byte = (r_state == S_LOAD) && rx_valid && !w_load_done;
  assign w_word_last = w_load_byte && (r_lane == 2'd3);
  // Words past DEPTH are counted but never written.
  assign w_mem_we    = w_word_last && (32'(r_idx) < DEPTH);
  assign w_fetch_ok  = (32'(cmd_id) < DEPTH);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    cmd_en      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_state_nxt = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (rx_valid) begin
          w_state_nxt = (w_len_full == 16'd0) ? S_IDLE : S_LOAD;
        end
      end
      S_LOAD: begin
        busy = 1'b1;
        if (w_load_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cmd_en = 1'b1;
        if (res_en) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (rx_valid) begin
          w_state_nxt = S_LEN_HI;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: length, index, lane packing, result, overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_len          <= 16'd0;
      r_idx          <= 16'd0;
      r_lane         <= 2'd0;
      r_word         <= 24'd0;
      r_result       <= 32'd0;
      r_result_valid <= 1'b0;
      r_ovf          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_len[7:0] <= rx_data;
          end
        end
        S_LEN_HI: begin
          if (rx_valid) begin
            r_len[15:8] <= rx_data;
            // A zero-length stream leaves index, lane and ovf untouched.
            if (w_len_full != 16'd0) begin
              r_idx  <= 16'd0;
              r_lane <= 2'd0;
              r_ovf  <= (32'(w_len_full) > DEPTH);
            end
          end
        end
        S_LOAD: begin
          if (w_load_byte) begin
            case (r_lane)
              2'd0:    r_word[7:0]   <= rx_data;
              2'd1:    r_word[15:8]  <= rx_data;
              2'd2:    r_word[23:16] <= rx_data;
              default: r_idx         <= r_idx + 16'd1;
            endcase
            r_lane <= r_lane + 2'd1;
          end
        end
        S_RUN: begin
          if (res_en) begin
            r_result       <= res;
            r_result_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (rx_valid) begin
            r_result_valid <= 1'b0;
            r_len[7:0]     <= rx_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Program memory (no reset: contents survive reset and partial loads)
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (w_mem_we) begin
      r_mem[r_idx[ADDR_W-1:0]] <= {rx_data, r_word};
    end
  end

  // Registered fetch, active in every state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd <= 32'd0;
    end else begin
      r_cmd <= w_fetch_ok ? r_mem[cmd_id[ADDR_W-1:0]] : 32'd0;
    end
  end

  assign cmd          = r_cmd;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cmd_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_loader
// Purpose  : Self-checking bench for cmd_loader. Two instances (ADDR_W=6 and
//            ADDR_W=2) share one stimulus stream; a transaction-level model
//            (word arrays per depth, expected run/result flags) predicts all
//            outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_loader;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [15:0] cmd_id = 16'd0;
  logic [31:0] res = 32'd0;
  logic        res_en = 1'b0;

  logic [31:0] cmd_a, result_a, cmd_b, result_b;
  logic        cmd_en_a, result_valid_a, busy_a, ovf_a;
  logic        cmd_en_b, result_valid_b, busy_b, ovf_b;

  always #5 sys_clk = ~sys_clk;

  cmd_loader #(.ADDR_W(6)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_id(cmd_id), .cmd(cmd_a), .cmd_en(cmd_en_a), .res(res), .res_en(res_en),
    .result(result_a), .result_valid(result_valid_a), .busy(busy_a), .ovf(ovf_a)
  );

  cmd_loader #(.ADDR_W(2)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_id(cmd_id), .cmd(cmd_b), .cmd_en(cmd_en_b), .res(res), .res_en(res_en),
    .result(result_b), .result_valid(result_valid_b), .busy(busy_b), .ovf(ovf_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [31:0] m_a [64];
  bit          wr_a [64];
  logic [31:0] m_b [4];
  bit          wr_b [4];
  logic [31:0] e_result = 32'd0;
  bit          e_rv = 1'b0;
  bit          e_run = 1'b0;
  bit          e_ovf_a = 1'b0;
  bit          e_ovf_b = 1'b0;
  logic [31:0] fixed_w [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit e_busy);
    chk({tag, "/busy_a"}, {31'd0, busy_a}, {31'd0, e_busy});
    chk({tag, "/busy_b"}, {31'd0, busy_b}, {31'd0, e_busy});
    chk({tag, "/cmd_en_a"}, {31'd0, cmd_en_a}, {31'd0, e_run});
    chk({tag, "/cmd_en_b"}, {31'd0, cmd_en_b}, {31'd0, e_run});
    chk({tag, "/result_a"}, result_a, e_result);
    chk({tag, "/result_b"}, result_b, e_result);
    chk({tag, "/rv_a"}, {31'd0, result_valid_a}, {31'd0, e_rv});
    chk({tag, "/rv_b"}, {31'd0, result_valid_b}, {31'd0, e_rv});
    chk({tag, "/ovf_a"}, {31'd0, ovf_a}, {31'd0, e_ovf_a});
    chk({tag, "/ovf_b"}, {31'd0, ovf_b}, {31'd0, e_ovf_b});
  endtask

  // Compare current cmd outputs against the model for address addr,
  // skipping words that have never been written.
  task automatic cmp_fetch(input string tag, input int addr);
    if (addr >= 64) chk({tag, "/cmd_a"}, cmd_a, 32'd0);
    else if (wr_a[addr]) chk({tag, "/cmd_a"}, cmd_a, m_a[addr]);
    if (addr >= 4) chk({tag, "/cmd_b"}, cmd_b, 32'd0);
    else if (wr_b[addr]) chk({tag, "/cmd_b"}, cmd_b, m_b[addr]);
  endtask

  task automatic fetch(input int addr);
    cmd_id = 16'(addr);
    tick();
    cmp_fetch("fetch", addr);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic gap(input bit en);
    if (en) repeat ($urandom_range(0, 2)) tick();
  endtask

  // Stream a program of n words. stop_after>0 returns right after that many
  // bytes (counting the two length bytes) without final checks.
  task automatic load(input int n, input int stop_after, input bit gaps);
    logic [15:0] nn;
    logic [31:0] w;
    int cnt;
    nn  = 16'(n);
    cnt = 0;
    send_byte(nn[7:0]);
    cnt++;
    e_rv = 1'b0;
    check_all("len_lo", 1'b1);
    gap(gaps);
    send_byte(nn[15:8]);
    cnt++;
    if (n == 0) begin
      check_all("len_zero", 1'b0);
      return;
    end
    e_ovf_a = (n > 64);
    e_ovf_b = (n > 4);
    check_all("len_hi", 1'b1);
    cmd_id = 16'(n - 1);
    for (int k = 0; k < n; k++) begin
      w = (k < fixed_w.size()) ? fixed_w[k] : $urandom;
      for (int j = 0; j < 4; j++) begin
        gap(gaps);
        send_byte(w[8*j +: 8]);
        cnt++;
        if (j == 3) begin
          if (k < 64) begin m_a[k] = w; wr_a[k] = 1'b1; end
          if (k < 4)  begin m_b[k] = w; wr_b[k] = 1'b1; end
        end
        if (stop_after != 0 && cnt == stop_after) return;
        if (!(k == n - 1 && j == 3)) begin
          chk("loading/busy_a", {31'd0, busy_a}, 32'd1);
          chk("loading/cmd_en_b", {31'd0, cmd_en_b}, 32'd0);
        end
      end
    end
    check_all("last_byte", 1'b1);
    tick();
    e_run = 1'b1;
    check_all("run_start", 1'b0);
    cmp_fetch("last_word", n - 1);
  endtask

  // Drive res_en for hold cycles (optionally with a byte in the first cycle).
  task automatic res_pulse(input logic [31:0] v, input int hold, input bit with_rx);
    res    = v;
    res_en = 1'b1;
    if (with_rx) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
    end
    tick();
    rx_valid = 1'b0;
    if (e_run) begin
      e_result = v;
      e_rv     = 1'b1;
      e_run    = 1'b0;
    end
    check_all("res", 1'b0);
    for (int i = 1; i < hold; i++) begin
      res = $urandom;
      tick();
      check_all("res_hold", 1'b0);
    end
    res_en = 1'b0;
    tick();
  endtask

  task automatic async_reset();
    #2;
    sys_rst_n = 1'b0;
    #1;
    e_run = 1'b0; e_rv = 1'b0; e_result = 32'd0; e_ovf_a = 1'b0; e_ovf_b = 1'b0;
    check_all("rst", 1'b0);
    chk("rst/cmd_a", cmd_a, 32'd0);
    chk("rst/cmd_b", cmd_b, 32'd0);
    tick();
    tick();
    #3;
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Power-on reset
    #3;
    async_reset();
    check_all("post_reset", 1'b0);

    // res_en outside RUN is ignored
    res_pulse(32'hDEADBEEF, 1, 1'b0);

    // Basic load N=2 and fetch
    fixed_w = '{32'h00000000, 32'h00000412};
    load(2, 0, 1'b0);
    fetch(1);
    chk("fetch1_const", cmd_a, 32'h00000412);
    fetch(0);

    // Bytes in RUN are ignored
    send_byte(8'h55);
    check_all("run_rx", 1'b0);

    // Result capture, held res_en captures once, later pulses ignored
    res_pulse(32'h000013BA, 3, 1'b0);
    chk("result_const", result_a, 32'h000013BA);
    res_pulse(32'h12345678, 1, 1'b0);

    // Zero-length stream
    load(0, 0, 1'b0);
    fixed_w = {};

    // Overflow on the small instance
    load(5, 0, 1'b1);
    for (int a = 0; a < 5; a++) fetch(a);
    fetch(100);

    // Simultaneous res_en and rx_valid in RUN
    res_pulse($urandom, 1, 1'b1);

    // Reload from DONE
    fixed_w = '{32'h00001E01};
    load(1, 0, 1'b0);
    fetch(0);
    chk("reload_const", cmd_b, 32'h00001E01);
    fixed_w = {};
    res_pulse($urandom, 2, 1'b0);

    // Reset during a load after byte 7
    load(3, 7, 1'b0);
    async_reset();
    load(1, 0, 1'b1);
    fetch(0);
    res_pulse($urandom, 1, 1'b0);

    // Randomized loads
    for (int it = 0; it < 8; it++) begin
      n = (it == 3) ? 66 : $urandom_range(1, 9);
      load(n, 0, 1'b1);
      for (int f = 0; f < 4; f++) fetch($urandom_range(0, n - 1));
      fetch($urandom_range(64, 65535));
      res_pulse($urandom, $urandom_range(1, 3), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmd_loader.md
# cmd_loader

Program store and run controller upstream of `cpu`. Receives a byte stream (from the UART receiver) carrying a length-prefixed program and packs it into 32-bit command words in an internal memory. Once loaded, it serves `cmd` for the CPU's `cmd_id` fetches and holds `cmd_en` high. It drops `cmd_en` and captures `res` when the CPU signals `res_en`.

## Interface
- `ADDR_W`, default 6: word-address width; memory depth is `DEPTH = 2**ADDR_W` words.
- `sys_clk` input 1: single clock; all logic on the rising edge.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: program byte.
- `rx_valid` input 1: one-cycle strobe; `rx_data` is valid this cycle.
- `cmd_id` input 16: CPU fetch index (word address).
- `cmd` output 32: command word for `cmd_id`, registered.
- `cmd_en` output 1: CPU run enable.
- `res` input 32: CPU result.
- `res_en` input 1: CPU result valid / halt.
- `result` output 32: captured `res`.
- `result_valid` output 1: `result` holds a fresh value.
- `busy` output 1: a load is in progress.
- `ovf` output 1: the last load declared more words than `DEPTH`.

## Operation
- Stream format:
  - byte 0 = N[7:0], byte 1 = N[15:8]: word count, 16-bit little-endian.
  - Then 4·N bytes: each word little-endian, so the first byte is `cmd[7:0]` (opcode).
  - Word k is stored at address k.
- States: IDLE, LEN_HI, LOAD, RUN, DONE.
- IDLE:
  - `rx_valid` → latch N[7:0], go to LEN_HI.
  - `busy`=1 from LEN_HI until leaving LOAD.
- LEN_HI:
  - `rx_valid` → latch N[15:8].
  - If N==0, return to IDLE; nothing is written and `ovf` is unchanged.
  - Otherwise clear the word index and byte lane, set `ovf` = (N > DEPTH), go to LOAD.
- LOAD:
  - Bytes are packed into lanes 0..3.
  - On the 4th byte the word is written to `mem[index]` if index < DEPTH; otherwise it is discarded but still counted.
  - The index increments with a 16-bit counter.
  - When the index reaches N, go to RUN.
- RUN:
  - `cmd_en`=1.
  - `res_en` sampled high → capture `result` ← `res`, set `result_valid`=1, set `cmd_en`=0, go to DONE.
  - `rx_valid` bytes are ignored.
- DONE:
  - `cmd_en`=0 and `result` is held.
  - `rx_valid` → clear `result_valid`, treat the byte as N[7:0], go to LEN_HI. This is a reload; memory is overwritten from address 0.
- Fetch path, active in every state:
  - `cmd` ← `mem[cmd_id[ADDR_W-1:0]]` if `cmd_id` < DEPTH, else 32'h00000000.
  - Memory not written by the current load keeps its previous contents. Memory is not cleared by reset; the bench must not read unwritten words.
- `rx_valid` in LEN_HI/LOAD is always consumed; there is no backpressure. The upstream byte rate is at most one per cycle.

## Timing
- Reset values:
  - state=IDLE.
  - `cmd`=0, `cmd_en`=0, `result`=0, `result_valid`=0, `busy`=0, `ovf`=0.
  - Internal counters and the lane register are 0.
- Reset is asynchronous mid-load or mid-run: the next state is IDLE, `cmd_en` falls immediately, and the partial load is abandoned.
- Fetch latency: `cmd_id` sampled at edge t → `cmd` valid after edge t+1. The CPU sees one-cycle registered read data.
- Word write: the memory is written at the edge that accepts the 4th byte of the word.
- `cmd_en` rises at the edge after the edge that accepted the final byte. A fetch of the last word is therefore correct on the first `cmd_en` cycle.
- `busy` falls at the same edge at which `cmd_en` rises.
- `res_en` → `cmd_en` low and `result_valid` high at the same edge (1-cycle latency).
- `res_en` held high across several cycles captures only once.
- `res_en` outside RUN is ignored.
- Simultaneous `res_en` and `rx_valid` in RUN: the result is captured and the byte is dropped.

## Test plan
- Load N=2, words 32'h00000000 and 32'h00000412, then hold `cmd_id`=1. Required:
  - `cmd`=32'h00000412 one cycle later.
  - `cmd_en` rises exactly 1 cycle after the 10th byte.
  - `busy` is high during bytes 2-9.
- In RUN, drive `res`=32'h000013BA with a `res_en` pulse. Required:
  - next edge: `result`=32'h000013BA, `result_valid`=1, `cmd_en`=0.
  - further `res_en` pulses leave `result` unchanged.
- Stream N=0 (bytes 00 00). Required: returns to IDLE, `cmd_en` stays 0, `ovf`=0. A following valid load then works.
- With ADDR_W=2, load N=5. Required:
  - `ovf`=1.
  - words 0-3 are readable.
  - word 4 is discarded.
  - `cmd_id`=4 returns 0.
  - `cmd_en` rises after byte 22.
- Assert `sys_rst_n`=0 after byte 7 of a load. Required:
  - all outputs go to their reset values asynchronously.
  - a subsequent full load of N=1 runs normally.
- From DONE, send a new N=1 program containing 32'h00001E01. Required:
  - `result_valid` clears on the first byte.
  - `cmd` at `cmd_id`=0 reads 32'h00001E01.
  - `cmd_en` re-asserts.
